mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_if.sv | 32 +++
 rtl/mem_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Processor-side and memory-side signal bundle for the memory controller.
// The slave modport is the controller's view; master is the view of the
// processor/memory environment driving it.
interface mem_ctrl_if;
    // Processor request side
    logic        iReq;
    logic        iWE;
    logic [31:0] iAddr;
    logic [31:0] iData;
    logic [31:0] oData;
    logic        oBusy;
    logic        oDone;
    logic        oFault;
    // Memory side
    logic        oMemRead;
    logic        oMemWrite;
    logic [31:0] oMemAddr;
    logic [31:0] oMemData;
    logic [31:0] iMemData;

    modport slave (
        input  iReq, iWE, iAddr, iData, iMemData,
        output oData, oBusy, oDone, oFault,
        output oMemRead, oMemWrite, oMemAddr, oMemData
    );

    modport master (
        output iReq, iWE, iAddr, iData, iMemData,
        input  oData, oBusy, oDone, oFault,
        input  oMemRead, oMemWrite, oMemAddr, oMemData
    );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port memory access controller.
// A request is accepted only in IDLE; it is range/alignment checked, then
// optionally delayed by WAIT_STATES idle cycles, performs a single one-cycle
// strobe in ACCESS and reports completion with a one-cycle oDone pulse.
// Faulted requests skip straight to DONE so their latency is fixed at 1.
module mem_ctrl #(
    parameter int WAIT_STATES = 0,
    parameter int MEM_WORDS   = 1024
) (
    input  logic        iClk,
    input  logic        iRst,
    mem_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0]  WAIT_CNT    = 4'(WAIT_STATES);
    localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mar_q, mar_d;      // byte address presented to memory
    logic [31:0] wdata_q, wdata_d;  // write data presented to memory
    logic [31:0] mdr_q, mdr_d;      // read data returned to processor
    logic        we_q, we_d;
    logic        fault_q, fault_d;
    logic        addr_bad;

    // Reject misaligned addresses and word indices past the end of memory.
    assign addr_bad = (bus.iAddr[1:0] != 2'b00) ||
                      ({2'b00, bus.iAddr[31:2]} >= MEM_WORDS_L);

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mar_q   <= '0;
            wdata_q <= '0;
            mdr_q   <= '0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mar_q   <= mar_d;
            wdata_q <= wdata_d;
            mdr_q   <= mdr_d;
            we_q    <= we_d;
            fault_q <= fault_d;
        end
    end

    // Next-state logic: requests are only looked at in IDLE, so anything
    // arriving while busy is dropped rather than queued.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mar_d   = mar_q;
        wdata_d = wdata_q;
        mdr_d   = mdr_q;
        we_d    = we_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.iReq) begin
                    mar_d   = bus.iAddr;
                    wdata_d = bus.iData;
                    we_d    = bus.iWE;
                    if (addr_bad) begin
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        fault_d = 1'b0;
                        if (WAIT_STATES > 0) begin
                            cnt_d   = WAIT_CNT;
                            state_d = ST_WAIT;
                        end else begin
                            state_d = ST_ACCESS;
                        end
                    end
                end
            end
            ST_WAIT: begin
                // Counter is loaded with WAIT_STATES on entry; leaving when it
                // reads 1 gives exactly WAIT_STATES cycles in this state.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                if (!we_q) begin
                    mdr_d = bus.iMemData;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state, so they are glitch-free and
    // both strobes are confined to the single ACCESS cycle.
    assign bus.oBusy     = (state_q != ST_IDLE);
    assign bus.oDone     = (state_q == ST_DONE);
    assign bus.oFault    = (state_q == ST_DONE) && fault_q;
    assign bus.oMemRead  = (state_q == ST_ACCESS) && !we_q;
    assign bus.oMemWrite = (state_q == ST_ACCESS) && we_q;
    assign bus.oMemAddr  = mar_q;
    assign bus.oMemData  = wdata_q;
    assign bus.oData     = mdr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: three instances with 0, 2 and 3 wait states
// share one clock and reset. Inputs change on the falling edge and outputs
// are sampled there; "cycle k" is the k-th clock period after the one in
// which a request was presented.
module tb_mem_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    mem_ctrl_if if0 ();
    mem_ctrl_if if2 ();
    mem_ctrl_if if3 ();

    mem_ctrl #(.WAIT_STATES(0), .MEM_WORDS(1024)) dut0 (.iClk(clk), .iRst(rst), .bus(if0));
    mem_ctrl #(.WAIT_STATES(2), .MEM_WORDS(1024)) dut2 (.iClk(clk), .iRst(rst), .bus(if2));
    mem_ctrl #(.WAIT_STATES(3), .MEM_WORDS(1024)) dut3 (.iClk(clk), .iRst(rst), .bus(if3));

    // Memory contents: word 4 holds 0xDEADBEEF, every other word holds
    // 0xA5A50000 OR'd with its byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[11:2] == 10'd4) return 32'hDEADBEEF;
        return 32'hA5A50000 | a;
    endfunction

    assign if0.iMemData = mem_word(if0.oMemAddr);
    assign if2.iMemData = mem_word(if2.oMemAddr);
    assign if3.iMemData = mem_word(if3.oMemAddr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        if0.iReq = 1'b1; if0.iWE = 1'b1; if0.iAddr = 32'h10; if0.iData = 32'hFFFFFFFF;
        repeat (2) tick;
        n_checks++;
        if ({if0.oData, if0.oMemAddr, if0.oMemData, if0.oBusy, if0.oDone, if0.oFault,
             if0.oMemRead, if0.oMemWrite} !== '0) begin
            n_fails++;
            $display("FAIL reset_dut0: busy=%b done=%b data=%h addr=%h, required all zero",
                     if0.oBusy, if0.oDone, if0.oData, if0.oMemAddr);
        end
        n_checks++;
        if ({if2.oData, if2.oMemAddr, if2.oMemData, if2.oBusy, if2.oDone, if2.oFault,
             if2.oMemRead, if2.oMemWrite} !== '0) begin
            n_fails++;
            $display("FAIL reset_dut2: busy=%b done=%b, required all zero", if2.oBusy, if2.oDone);
        end
        n_checks++;
        if ({if3.oData, if3.oMemAddr, if3.oMemData, if3.oBusy, if3.oDone, if3.oFault,
             if3.oMemRead, if3.oMemWrite} !== '0) begin
            n_fails++;
            $display("FAIL reset_dut3: busy=%b done=%b, required all zero", if3.oBusy, if3.oDone);
        end
        if0.iReq = 1'b0;
        rst = 1'b0;
        tick;
        n_checks++;
        if (if0.oBusy !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_idle_after: busy=%b, required 0", if0.oBusy);
        end
        $display("reset: outputs checked on all instances");
    endtask

    task automatic test_write_w0;
        if0.iReq = 1'b1; if0.iWE = 1'b1; if0.iAddr = 32'h10; if0.iData = 32'h12345678;
        tick; // cycle 1: ACCESS
        if0.iReq = 1'b0;
        n_checks++;
        if ({if0.oMemWrite, if0.oMemRead, if0.oBusy, if0.oDone} !== 4'b1010) begin
            n_fails++;
            $display("FAIL w0_access_strobes: wr/rd/busy/done=%b, required 1010",
                     {if0.oMemWrite, if0.oMemRead, if0.oBusy, if0.oDone});
        end
        n_checks++;
        if (if0.oMemAddr !== 32'h10 || if0.oMemData !== 32'h12345678) begin
            n_fails++;
            $display("FAIL w0_bus: addr=%h data=%h, required 00000010 12345678",
                     if0.oMemAddr, if0.oMemData);
        end
        tick; // cycle 2: DONE
        n_checks++;
        if ({if0.oDone, if0.oFault, if0.oMemWrite, if0.oMemRead} !== 4'b1000) begin
            n_fails++;
            $display("FAIL w0_done: done/fault/wr/rd=%b, required 1000",
                     {if0.oDone, if0.oFault, if0.oMemWrite, if0.oMemRead});
        end
        n_checks++;
        if (if0.oData !== 32'h0) begin
            n_fails++;
            $display("FAIL w0_odata_hold: oData=%h, required 00000000", if0.oData);
        end
        tick; // cycle 3: IDLE
        n_checks++;
        if ({if0.oBusy, if0.oDone} !== 2'b00) begin
            n_fails++;
            $display("FAIL w0_idle: busy/done=%b, required 00", {if0.oBusy, if0.oDone});
        end
        $display("write w0: addr=%h data=%h", 32'h10, 32'h12345678);
    endtask

    task automatic test_read_w3;
        if3.iReq = 1'b1; if3.iWE = 1'b0; if3.iAddr = 32'h10; if3.iData = 32'h0;
        for (int c = 1; c <= 6; c++) begin
            tick;
            if3.iReq = 1'b0;
            n_checks++;
            if (if3.oMemRead !== (c == 4) || if3.oMemWrite !== 1'b0 || if3.oDone !== (c == 5)) begin
                n_fails++;
                $display("FAIL w3_read_timing: cycle %0d rd=%b wr=%b done=%b, required rd=%b wr=0 done=%b",
                         c, if3.oMemRead, if3.oMemWrite, if3.oDone, c == 4, c == 5);
            end
        end
        n_checks++;
        if (if3.oData !== 32'hDEADBEEF) begin
            n_fails++;
            $display("FAIL w3_read_data: oData=%h, required deadbeef", if3.oData);
        end
        $display("read w3: addr=%h data=%h", 32'h10, if3.oData);
    endtask

    task automatic test_fault;
        logic [31:0] addrs [3];
        addrs[0] = 32'h12;
        addrs[1] = 32'h1000;
        addrs[2] = 32'hFFC;   // last valid word, must not fault
        for (int i = 0; i < 2; i++) begin
            if3.iReq = 1'b1; if3.iWE = 1'b0; if3.iAddr = addrs[i];
            tick;
            if3.iReq = 1'b0;
            n_checks++;
            if ({if3.oDone, if3.oFault, if3.oMemRead, if3.oMemWrite} !== 4'b1100) begin
                n_fails++;
                $display("FAIL fault_w3: addr=%h done/fault/rd/wr=%b, required 1100",
                         addrs[i], {if3.oDone, if3.oFault, if3.oMemRead, if3.oMemWrite});
            end
            tick;
            n_checks++;
            if ({if3.oDone, if3.oFault, if3.oBusy} !== 3'b000 || if3.oData !== 32'hDEADBEEF) begin
                n_fails++;
                $display("FAIL fault_after_w3: addr=%h done/fault/busy=%b oData=%h, required 000 deadbeef",
                         addrs[i], {if3.oDone, if3.oFault, if3.oBusy}, if3.oData);
            end
            $display("fault w3: addr=%h", addrs[i]);
        end
        // Misaligned write on the zero-wait instance: no write strobe at all.
        if0.iReq = 1'b1; if0.iWE = 1'b1; if0.iAddr = 32'h3; if0.iData = 32'hAAAA5555;
        tick;
        if0.iReq = 1'b0;
        n_checks++;
        if ({if0.oDone, if0.oFault, if0.oMemWrite} !== 3'b110) begin
            n_fails++;
            $display("FAIL fault_w0: done/fault/wr=%b, required 110",
                     {if0.oDone, if0.oFault, if0.oMemWrite});
        end
        tick;
        // Boundary: the last word in memory reads normally with W=0.
        if0.iReq = 1'b1; if0.iWE = 1'b0; if0.iAddr = addrs[2];
        tick;
        if0.iReq = 1'b0;
        tick;
        n_checks++;
        if ({if0.oDone, if0.oFault} !== 2'b10 || if0.oData !== 32'hA5A50FFC) begin
            n_fails++;
            $display("FAIL last_word_w0: done/fault=%b oData=%h, required 10 a5a50ffc",
                     {if0.oDone, if0.oFault}, if0.oData);
        end
        tick;
        $display("fault w0: addr=%h, last-word read addr=%h", 32'h3, addrs[2]);
    endtask

    task automatic test_ignore_busy;
        int n_done, n_rd, n_wr;
        n_done = 0; n_rd = 0; n_wr = 0;
        if2.iReq = 1'b1; if2.iWE = 1'b0; if2.iAddr = 32'h20; if2.iData = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            tick;
            if (c <= 3) begin
                if2.iReq = 1'b1; if2.iWE = 1'b1; if2.iAddr = 32'h40; if2.iData = 32'h0BADF00D;
            end else begin
                if2.iReq = 1'b0;
            end
            if (if2.oDone === 1'b1) n_done++;
            if (if2.oMemRead === 1'b1) n_rd++;
            if (if2.oMemWrite === 1'b1) n_wr++;
            if (c == 4) begin
                n_checks++;
                if (if2.oMemAddr !== 32'h20 || if2.oDone !== 1'b1) begin
                    n_fails++;
                    $display("FAIL ignore_addr_stable: addr=%h done=%b, required 00000020 1",
                             if2.oMemAddr, if2.oDone);
                end
            end
        end
        n_checks++;
        if (n_done != 1 || n_rd != 1 || n_wr != 0) begin
            n_fails++;
            $display("FAIL ignore_counts: done=%0d rd=%0d wr=%0d, required 1 1 0", n_done, n_rd, n_wr);
        end
        n_checks++;
        if (if2.oData !== 32'hA5A50020) begin
            n_fails++;
            $display("FAIL ignore_data: oData=%h, required a5a50020", if2.oData);
        end
        $display("ignore w2: dones=%0d reads=%0d writes=%0d", n_done, n_rd, n_wr);
    endtask

    task automatic test_back_to_back;
        int done_cyc [$];
        if2.iReq = 1'b1; if2.iWE = 1'b0; if2.iAddr = 32'h20;
        for (int c = 1; c <= 20; c++) begin
            tick;
            if (c == 11) if2.iReq = 1'b0;
            if (if2.oDone === 1'b1) done_cyc.push_back(c);
        end
        n_checks++;
        if (done_cyc.size() != 3) begin
            n_fails++;
            $display("FAIL b2b_count: dones=%0d, required 3", done_cyc.size());
        end else begin
            n_checks++;
            if (done_cyc[0] != 4 || done_cyc[1] != 9 || done_cyc[2] != 14) begin
                n_fails++;
                $display("FAIL b2b_spacing: done cycles %0d %0d %0d, required 4 9 14",
                         done_cyc[0], done_cyc[1], done_cyc[2]);
            end
        end
        $display("back_to_back w2: %0d dones", done_cyc.size());
    endtask

    task automatic test_reset_abort;
        int n_ev;
        n_ev = 0;
        if3.iReq = 1'b1; if3.iWE = 1'b0; if3.iAddr = 32'h10;
        tick;           // cycle 1: WAIT
        if3.iReq = 1'b0;
        tick;           // cycle 2: WAIT
        rst = 1'b1;
        tick;           // cycle 3: after reset edge
        rst = 1'b0;
        n_checks++;
        if ({if3.oData, if3.oMemAddr, if3.oMemData, if3.oBusy, if3.oDone, if3.oFault,
             if3.oMemRead, if3.oMemWrite} !== '0) begin
            n_fails++;
            $display("FAIL abort_zero: busy=%b data=%h addr=%h, required all zero",
                     if3.oBusy, if3.oData, if3.oMemAddr);
        end
        for (int c = 0; c < 8; c++) begin
            tick;
            if (if3.oDone === 1'b1 || if3.oMemRead === 1'b1 || if3.oMemWrite === 1'b1) n_ev++;
        end
        n_checks++;
        if (n_ev != 0) begin
            n_fails++;
            $display("FAIL abort_quiet: %0d strobe/done cycles, required 0", n_ev);
        end
        if3.iReq = 1'b1; if3.iWE = 1'b0; if3.iAddr = 32'h10;
        for (int c = 1; c <= 5; c++) begin
            tick;
            if3.iReq = 1'b0;
        end
        n_checks++;
        if ({if3.oDone, if3.oFault} !== 2'b10 || if3.oData !== 32'hDEADBEEF) begin
            n_fails++;
            $display("FAIL abort_recover: done/fault=%b oData=%h, required 10 deadbeef",
                     {if3.oDone, if3.oFault}, if3.oData);
        end
        tick;
        $display("reset_abort w3: recovered oData=%h", if3.oData);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        if0.iReq = 1'b0; if0.iWE = 1'b0; if0.iAddr = '0; if0.iData = '0;
        if2.iReq = 1'b0; if2.iWE = 1'b0; if2.iAddr = '0; if2.iData = '0;
        if3.iReq = 1'b0; if3.iWE = 1'b0; if3.iAddr = '0; if3.iData = '0;
        tick;
        test_reset();
        test_write_w0();
        test_read_w3();
        test_fault();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
